// File: rtl/alarm_tone_i2s_pkg.sv
// Shared types and constants for the alarm tone I2S back-end.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEEP = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int unsigned SLOT_BITS  = 16;
    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned SLOT_W     = $clog2(SLOT_BITS);
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
    localparam int unsigned DIV_BITS   = 4;
    localparam int unsigned MCLK_TAP   = 1;
    localparam int unsigned SCLK_TAP   = 3;

    // Slot position p carries sample bit (16 - p) mod 16: the one-bit I2S delay.
    function automatic logic [SLOT_W-1:0] slot_bit(input logic [SLOT_W-1:0] p);
        return '0 - p;
    endfunction

endpackage

// File: rtl/alarm_tone_i2s_if.sv
// Pin bundle between the lock controller / DAC and the alarm tone back-end.
interface alarm_tone_i2s_if;

    logic alarm_en;
    logic Pause;
    logic M_CLK;
    logic S_CLK;
    logic LR_CLK;
    logic Sin;
    logic busy;

    modport master (
        output alarm_en, Pause,
        input  M_CLK, S_CLK, LR_CLK, Sin, busy
    );

    modport slave (
        input  alarm_en, Pause,
        output M_CLK, S_CLK, LR_CLK, Sin, busy
    );

endinterface

// File: rtl/alarm_tone_i2s_serializer.sv
// I2S transmitter: clock prescaler, bit counter, sample latch and serial data mux.
module i2s_tx_serializer
    import alarm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SLOT_BITS-1:0] sample_i,
    output logic                 mclk_o,
    output logic                 sclk_o,
    output logic                 lrclk_o,
    output logic                 sin_o,
    output logic                 frame_tick_o,
    output logic                 latch_tick_o
);

    logic [DIV_BITS-1:0]  div_q;
    logic [BIT_W-1:0]     bitcnt_q;
    logic [BIT_W-1:0]     bitcnt_d;
    logic [SLOT_BITS-1:0] sample_q;
    logic [SLOT_BITS-1:0] word;
    logic                 sin_q;
    logic                 sin_d;
    logic                 sfall;

    // The word latched on this edge must already drive the MSB for slot 1.
    always_comb begin
        sfall        = (div_q == '1);
        bitcnt_d     = bitcnt_q + 1'b1;
        frame_tick_o = sfall && (bitcnt_q == '1);
        latch_tick_o = sfall && (bitcnt_q == '0);
        word         = latch_tick_o ? sample_i : sample_q;
        sin_d        = word[slot_bit(bitcnt_d[SLOT_W-1:0])];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            bitcnt_q <= '0;
            sample_q <= '0;
            sin_q    <= 1'b0;
        end else begin
            div_q <= div_q + 1'b1;
            if (sfall) begin
                bitcnt_q <= bitcnt_d;
                sin_q    <= sin_d;
                if (latch_tick_o) begin
                    sample_q <= sample_i;
                end
            end
        end
    end

    assign mclk_o  = div_q[MCLK_TAP];
    assign sclk_o  = div_q[SCLK_TAP];
    assign lrclk_o = bitcnt_q[BIT_W-1];
    assign sin_o   = sin_q;

endmodule

// File: rtl/alarm_tone_i2s.sv
// Alarm tone back-end: beep cadence FSM and square-wave tone generator driving an I2S DAC.
// Define ALARM_TWO_TONE_EN to alternate tone A and tone B on successive beeps.
module alarm_tone_i2s
    import alarm_pkg::*;
#(
    parameter int unsigned          TONE_HALF_A = 49,
    parameter int unsigned          TONE_HALF_B = 33,
    parameter int unsigned          ON_FRAMES   = 24414,
    parameter int unsigned          OFF_FRAMES  = 24414,
    parameter logic [SLOT_BITS-1:0] AMP         = 16'h2000
) (
    input  logic            clk,
    input  logic            reset,
    alarm_tone_i2s_if.slave bus
);

    localparam int unsigned HALF_MAX = (TONE_HALF_A > TONE_HALF_B) ? TONE_HALF_A : TONE_HALF_B;
    localparam int unsigned PHASE_W  = $clog2(HALF_MAX + 1);
    localparam logic [15:0] ON_LAST  = 16'(ON_FRAMES - 1);
    localparam logic [15:0] OFF_LAST = 16'(OFF_FRAMES - 1);
    localparam logic [SLOT_BITS-1:0] NEG_AMP = ~AMP + 1'b1;

    state_t               state_q;
    logic [15:0]          frame_cnt_q;
    logic [PHASE_W-1:0]   phase_q;
    logic [PHASE_W-1:0]   half_last;
    logic                 neg_q;
    logic                 busy_q;
    logic [SLOT_BITS-1:0] next_sample;
    logic                 frame_tick;
    logic                 latch_tick;
    logic                 mclk;
    logic                 sclk;
    logic                 lrclk;
    logic                 sin;

`ifdef ALARM_TWO_TONE_EN
    logic tone_sel_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tone_sel_q <= 1'b0;
        end else if (frame_tick && !bus.Pause && bus.alarm_en) begin
            if (state_q == IDLE) begin
                tone_sel_q <= 1'b0;
            end else if (state_q == GAP && frame_cnt_q == OFF_LAST) begin
                tone_sel_q <= ~tone_sel_q;
            end
        end
    end

    assign half_last = tone_sel_q ? PHASE_W'(TONE_HALF_B - 1) : PHASE_W'(TONE_HALF_A - 1);
`else
    assign half_last = PHASE_W'(TONE_HALF_A - 1);
`endif

    // Cadence only advances on frame boundaries; Pause freezes everything here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            phase_q     <= '0;
            neg_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else if (frame_tick && !bus.Pause) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.alarm_en) begin
                        state_q     <= BEEP;
                        busy_q      <= 1'b1;
                        frame_cnt_q <= '0;
                        phase_q     <= '0;
                        neg_q       <= 1'b0;
                    end
                end
                BEEP: begin
                    if (!bus.alarm_en) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        frame_cnt_q <= '0;
                    end else if (frame_cnt_q == ON_LAST) begin
                        state_q     <= GAP;
                        frame_cnt_q <= '0;
                    end else begin
                        frame_cnt_q <= frame_cnt_q + 1'b1;
                        if (phase_q == half_last) begin
                            phase_q <= '0;
                            neg_q   <= ~neg_q;
                        end else begin
                            phase_q <= phase_q + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (frame_cnt_q == OFF_LAST) begin
                        frame_cnt_q <= '0;
                        if (bus.alarm_en) begin
                            state_q <= BEEP;
                            phase_q <= '0;
                            neg_q   <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        frame_cnt_q <= frame_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // The serialiser only reads the sample on its latch strobe, so zero it elsewhere.
    always_comb begin
        next_sample = '0;
        if (latch_tick && state_q == BEEP && !bus.Pause) begin
            next_sample = neg_q ? NEG_AMP : AMP;
        end
    end

    i2s_tx_serializer u_ser (
        .clk          (clk),
        .rst          (reset),
        .sample_i     (next_sample),
        .mclk_o       (mclk),
        .sclk_o       (sclk),
        .lrclk_o      (lrclk),
        .sin_o        (sin),
        .frame_tick_o (frame_tick),
        .latch_tick_o (latch_tick)
    );

    assign bus.M_CLK  = mclk;
    assign bus.S_CLK  = sclk;
    assign bus.LR_CLK = lrclk;
    assign bus.Sin    = sin;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_alarm_tone_i2s.sv
// Directed bench for alarm_tone_i2s: frame-level cadence model feeding an I2S word scoreboard.
module tb_alarm_tone_i2s;

    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int HA  = 2;
    localparam int HB  = 1;
    localparam logic [15:0] AMP = 16'h2000;
`ifdef ALARM_TWO_TONE_EN
    localparam bit TWO_TONE = 1'b1;
`else
    localparam bit TWO_TONE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    alarm_tone_i2s_if bus ();

    alarm_tone_i2s #(
        .TONE_HALF_A (HA),
        .TONE_HALF_B (HB),
        .ON_FRAMES   (ON),
        .OFF_FRAMES  (OFF),
        .AMP         (AMP)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    logic [15:0] exp_q[$];

    int m_state = 0;
    int m_cnt   = 0;
    int m_bidx  = 0;
    bit cur_a   = 1'b0;
    bit cur_p   = 1'b0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Frame-level cadence model, stepped once per frame boundary.
    task automatic model_step();
        if (!cur_p) begin
            case (m_state)
                0: if (cur_a) begin
                       m_state = 1; m_cnt = 0; m_bidx = 0;
                   end
                1: if (!cur_a) begin
                       m_state = 0; m_cnt = 0;
                   end else if (m_cnt == ON - 1) begin
                       m_state = 2; m_cnt = 0;
                   end else begin
                       m_cnt++;
                   end
                default: if (m_cnt == OFF - 1) begin
                       m_cnt = 0;
                       if (cur_a) begin
                           m_state = 1; m_bidx++;
                       end else begin
                           m_state = 0;
                       end
                   end else begin
                       m_cnt++;
                   end
            endcase
        end
    endtask

    function automatic logic [15:0] model_word();
        int half;
        if (cur_p || m_state != 1) return 16'h0000;
        half = (TWO_TONE && m_bidx[0]) ? HB : HA;
        return ((m_cnt / half) % 2 == 1) ? (16'h0000 - AMP) : AMP;
    endfunction

    task automatic push_frame();
        logic [15:0] w;
        w = model_word();
        exp_q.push_back(w);
        exp_q.push_back(w);
    endtask

    // Runs one frame; inputs for the next frame change mid-frame at offset 256.
    task automatic run_frame(input bit na, input bit np);
        logic [31:0] c;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            cyc++;
            c = cyc;
            check("m_clk",  16'(bus.M_CLK),  16'(c[1]));
            check("s_clk",  16'(bus.S_CLK),  16'(c[3]));
            check("lr_clk", 16'(bus.LR_CLK), 16'(c[8]));
            if (cyc % 512 == 100) check("busy", 16'(bus.busy), 16'(m_state != 0));
            if (cyc % 512 == 256) begin
                bus.alarm_en = na;
                bus.Pause    = np;
                cur_a        = na;
                cur_p        = np;
            end
            if (cyc % 512 == 0) begin
                model_step();
                push_frame();
            end
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_mclk",  16'(bus.M_CLK),  16'h0);
        check("rst_sclk",  16'(bus.S_CLK),  16'h0);
        check("rst_lrclk", 16'(bus.LR_CLK), 16'h0);
        check("rst_sin",   16'(bus.Sin),    16'h0);
        check("rst_busy",  16'(bus.busy),   16'h0);
    endtask

    // I2S receiver: a word completes at the slot-0 rise after each LR_CLK change.
    logic [15:0] sh      = '0;
    logic        prev_lr = 1'b0;
    always @(posedge bus.S_CLK or posedge rst) begin
        logic [15:0] w;
        if (rst) begin
            sh      <= '0;
            prev_lr <= 1'b0;
            exp_q.delete();
        end else begin
            w = {sh[14:0], bus.Sin};
            sh      <= w;
            prev_lr <= bus.LR_CLK;
            if (bus.LR_CLK != prev_lr) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    assert (exp_q.size() != 0) else begin
                        errors++;
                        $error("FAIL word_unexpected observed=%h expected=none", w);
                    end
                end else begin
                    check(prev_lr ? "word_R" : "word_L", w, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bus.alarm_en = 1'b0;
        bus.Pause    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        cyc = 0;
        push_frame();

        // Idle frames; alarm raised mid-frame 3.
        run_frame(1'b0, 1'b0);
        run_frame(1'b0, 1'b0);
        run_frame(1'b0, 1'b0);
        run_frame(1'b1, 1'b0);
        // Two full beep/gap cycles and the start of a third beep.
        repeat (13) run_frame(1'b1, 1'b0);
        // Pause for three frames inside a beep, then resume.
        run_frame(1'b1, 1'b1);
        run_frame(1'b1, 1'b1);
        run_frame(1'b1, 1'b1);
        run_frame(1'b1, 1'b0);
        // Drop alarm mid-beep, then re-raise.
        run_frame(1'b0, 1'b0);
        run_frame(1'b1, 1'b0);
        repeat (4) run_frame(1'b1, 1'b0);
        // Drop alarm during the gap: gap must still run to completion.
        run_frame(1'b0, 1'b0);
        run_frame(1'b0, 1'b0);
        run_frame(1'b1, 1'b0);
        run_frame(1'b1, 1'b0);

        // Asynchronous reset mid-frame with alarm still requested.
        repeat (300) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst     = 1'b0;
        cyc     = 0;
        m_state = 0;
        m_cnt   = 0;
        m_bidx  = 0;
        push_frame();
        repeat (12) run_frame(1'b1, 1'b0);

        repeat (530) @(negedge clk);
        check("drain", 16'(exp_q.size()), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/alarm_tone_i2s.md
# alarm_tone_i2s

Audio back-end for the alarm lock. Consumes the lock controller's alarm request and drives the on-board I2S DAC pins (M_CLK, S_CLK, LR_CLK, Sin). Generates a beeping square-wave tone with programmable cadence and serialises the same 16-bit sample on both channels in standard I2S format. DAC clocks run continuously from reset release.

## Interface
- TONE_HALF_A, 49: half-period of tone A, in frames.
- TONE_HALF_B, 33: half-period of tone B, in frames. Used only with ALARM_TWO_TONE_EN.
- ON_FRAMES, 24414: beep length, in frames.
- OFF_FRAMES, 24414: gap length, in frames.
- AMP, 16'h2000: tone amplitude, positive two's complement.
- clk in 1: system clock.
- reset in 1: asynchronous, active-high.
- alarm_en in 1: alarm request from the lock FSM; level-sensitive.
- Pause in 1: holds the tone sequence and mutes output.
- M_CLK out 1: DAC master clock, clk/4.
- S_CLK out 1: bit clock, clk/16.
- LR_CLK out 1: word select; 0 = left, 1 = right; 32 S_CLK per frame.
- Sin out 1: serial data.
- busy out 1: high when state ≠ IDLE.

## Operation
- Prescaler: 4-bit free-running counter `div`.
  - M_CLK = div[1]; S_CLK = div[3].
  - An "S_CLK fall" is the clk edge where div wraps 15→0.
- Bit counter: 5-bit `bitcnt`, advances on every S_CLK fall.
  - LR_CLK = bitcnt[4].
  - Slot position p = bitcnt[3:0].
- Sin changes only on an S_CLK fall.
  - Sin = sample[(16−p) mod 16].
  - So p=0 carries the LSB of the previous word and p=1..15 carry bits 15..1 (I2S one-bit delay).
- `sample` register latches on the S_CLK fall where bitcnt goes 0→1. Both channels carry the same word.
- Frame boundary: the S_CLK fall where bitcnt goes 31→0. All state and counter updates happen here only, except while Pause is high.
- States:
  - IDLE → BEEP: when alarm_en = 1.
  - BEEP → GAP: when frame_cnt = ON_FRAMES−1.
  - BEEP → IDLE: when alarm_en = 0; this takes priority over the GAP transition.
  - GAP → BEEP: when frame_cnt = OFF_FRAMES−1 and alarm_en = 1.
  - GAP → IDLE: when frame_cnt = OFF_FRAMES−1 and alarm_en = 0.
  - GAP with alarm_en = 0 before the count expires: stay in GAP until the count expires.
- frame_cnt (16 bits) clears on every state change.
- Tone generation:
  - On BEEP entry: phase clears and the level starts at +AMP.
  - Level toggles to −AMP (two's complement) after every TONE_HALF frames.
- Next-sample value: +AMP or −AMP in BEEP; 0 in IDLE, in GAP, and whenever Pause = 1.
- Pause = 1: state, frame_cnt and phase freeze; clocks and serialiser keep running. Release resumes exactly where it stopped.
- alarm_en or Pause changing mid-frame has no effect until the next boundary or sample latch.

## Timing
- All outputs are registered. After reset, every output is 0, state = IDLE, div = 0, bitcnt = 0.
- The first S_CLK rise is 8 clk after reset release.
- Frame length is 512 clk.
- alarm_en rise to state = BEEP: at most 512 clk, i.e. the next boundary.
- The first tone MSB appears on Sin at p = 1 of that same frame.
- Beep and gap durations are exact to the frame: ON_FRAMES×512 clk and OFF_FRAMES×512 clk.

## Configuration
- ALARM_TWO_TONE_EN defined:
  - A tone-select flag chooses the half-period, TONE_HALF_A when 0 and TONE_HALF_B when 1.
  - The flag clears on IDLE→BEEP and toggles on each GAP→BEEP.
  - Effect: successive beeps alternate A, B, A, …
- ALARM_TWO_TONE_EN undefined: every beep uses TONE_HALF_A and the flag logic is absent.

## Structure
- Package alarm_pkg holds:
  - the state enum (IDLE, BEEP, GAP);
  - SLOT_BITS = 16 and FRAME_BITS = 32;
  - the prescaler-tap constants.
- Sub-module i2s_tx_serializer owns div, bitcnt, the sample latch and the Sin mux.
  - Inputs: the next-sample value.
  - Outputs: M_CLK, S_CLK, LR_CLK, Sin, plus one-cycle strobes `frame_tick` and `latch_tick`.
- The top level holds the cadence FSM and the tone generator.

## Test plan
Sim parameters: ON_FRAMES=4, OFF_FRAMES=2, TONE_HALF_A=2, TONE_HALF_B=1, AMP=16'h2000.

- Reset, alarm_en = 0 for 4 frames → M_CLK period 4 clk, S_CLK period 16 clk, LR_CLK period 512 clk; Sin constant 0; busy = 0.
- Raise alarm_en mid-frame → busy rises at the next boundary. Decoded words: +0x2000 ×2 frames, 0xE000 ×2 frames, then 0 ×2 frames (GAP), then repeat.
- I2S alignment → the MSB of 0x2000 appears on the S_CLK fall one slot after each LR_CLK edge; identical words on left and right.
- Pause high for 3 frames during BEEP → decoded words are 0 during pause; on release the remaining BEEP frames and phase continue without restart.
- Drop alarm_en in BEEP and, separately, in GAP → BEEP returns to IDLE at the next boundary; GAP returns to IDLE only after the gap expires.
- Assert reset mid-frame → all outputs 0 immediately, state IDLE. With ALARM_TWO_TONE_EN defined, the second beep toggles every frame (0x2000, 0xE000, …).
